div_seq: RTL and testbench
==========================

Name: div_seq

Overview:
- Multi-cycle divide sequencer that the EX stage uses for DIV/DIVU.
- It owns a WIDTH-iteration restoring divider and its state machine.
- It stalls the pipeline until the result is ready, and returns the quotient and remainder for the HI/LO write.
- EX holds start_i and the operands stable until it sees ready_o, then drops start_i.

Parameters:
- WIDTH, 32, operand width. Result is 2*WIDTH bits.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  asynchronous reset, active-high (`RSTENABLE = 1'b1).
- start_i  input  1  divide request from EX, held until ready_o is seen.
- annul_i  input  1  flush/cancel of the in-flight divide (e.g. branch-delay annul).
- signed_div_i  input  1  1 = DIV (two's complement), 0 = DIVU.
- opdata1_i  input  WIDTH  dividend.
- opdata2_i  input  WIDTH  divisor.
- result_o  output  2*WIDTH  {remainder, quotient}, valid while ready_o = 1.
- ready_o  output  1  result valid (registered).
- stallreq_o  output  1  pipeline stall request (combinational).

Behaviour:
- Reset is asynchronous: state=IDLE, cnt=0, result_o=0, ready_o=0, internal dividend/divisor registers=0.
- State machine: IDLE, BYZERO, ON, END. The state is registered; result_o and ready_o are registered.
- IDLE:
  - start_i=1 and annul_i=0 with opdata2_i=0 -> BYZERO.
  - start_i=1 and annul_i=0 with opdata2_i!=0 -> ON, cnt=0. Latch the absolute values of the operands (signed mode with a negative operand -> two's-complement negate; 0x80000000 stays 0x80000000 and is treated as unsigned 2^31). Latch the sign flags.
  - Otherwise stay in IDLE, ready_o=0, result_o=0.
- BYZERO: next edge -> END with result_o=0 and ready_o=1.
- ON, one restoring iteration per cycle:
  - Partial remainder shifts left by 1 and takes the next dividend MSB.
  - If partial remainder >= divisor, subtract the divisor and shift in quotient bit 1; else shift in 0.
  - The subtract compare is WIDTH+1 bits wide, so there is no overflow at 2^31.
  - cnt increments. On the iteration with cnt=WIDTH-1 -> END.
  - Sign fixup at the same edge: quotient negated if the sign flags differ (signed only); remainder takes the dividend's sign (signed only).
  - result_o = {remainder, quotient}, ready_o=1.
- Abort: in BYZERO or ON, annul_i=1 or start_i=0 -> IDLE at the next edge. ready_o stays 0, result_o=0, cnt=0. Annul has priority over iteration completion on the same edge.
- END:
  - Hold result_o and ready_o=1 while start_i=1.
  - start_i=0 -> IDLE, ready_o=0, result_o=0.
  - annul_i in END is ignored; the result is already committed by EX.
- Latency, with E0 = the accept edge:
  - Nonzero divisor: ready_o=1 after edge E0+WIDTH (32 cycles).
  - Zero divisor: ready_o=1 after E0+1.
- stallreq_o = start_i & ~ready_o & ~annul_i.
  - Asserted in the issue cycle and throughout BYZERO/ON.
  - Deasserted in the cycle ready_o=1, so EX completes and advances.
- A back-to-back divide needs one IDLE cycle (start_i low) between requests.
- Signed overflow 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0 (wraps, no trap).
- Reset asserted mid-operation -> immediate IDLE, outputs cleared, no result.

Test Plan:
- DIVU 100/7, start_i held -> stallreq_o=1 for 32 cycles; ready_o rises 32 cycles after accept; result_o={0x00000002,0x0000000E}; drop start_i -> next cycle ready_o=0, result_o=0.
- DIV -7/2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. DIV 7/-2 -> quotient 0xFFFFFFFD, remainder 0x00000001.
- Divide by zero (opdata2_i=0) -> ready_o=1 one cycle after accept, result_o=0, stallreq_o low from that cycle.
- Edge values:
  - DIVU 0xFFFFFFFF/1 -> quotient 0xFFFFFFFF, remainder 0.
  - DIV 0x80000000/0xFFFFFFFF -> quotient 0x80000000, remainder 0.
  - DIVU 3/5 -> quotient 0, remainder 3.
- annul_i pulse at iteration 10 -> IDLE next edge, ready_o never asserts, stallreq_o low while annul_i=1. A fresh start afterwards gives the correct result (13/4 -> quotient 3, remainder 1).
- Async rst asserted mid-ON (between clock edges) -> outputs 0 immediately. After release, a new DIVU 9/3 -> quotient 3, remainder 0, full 32-cycle latency.

Source files
------------

// File: rtl/div_seq.sv
// Multi-cycle restoring divider for DIV/DIVU: one quotient bit per cycle,
// stalls EX until {remainder, quotient} is ready for the HI/LO write.
module div_seq #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               annul_i,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               stallreq_o
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_BYZERO, ST_ON, ST_END} state_t;

  state_t               state_reg, state_next;
  logic [CW-1:0]        cnt_reg, cnt_next;
  logic [WIDTH-1:0]     rem_reg, rem_next;
  logic [WIDTH-1:0]     quo_reg, quo_next;
  logic [WIDTH-1:0]     divisor_reg, divisor_next;
  logic                 neg1_reg, neg1_next;
  logic                 neg2_reg, neg2_next;
  logic [2*WIDTH-1:0]   result_reg, result_next;
  logic                 ready_reg, ready_next;

  logic                 accept, abort, last_iter;
  logic [WIDTH-1:0]     abs1, abs2;
  logic [WIDTH:0]       shifted;
  logic [WIDTH-1:0]     sub;
  logic                 fits;
  logic [WIDTH-1:0]     rem_step, quo_step, rem_fix, quo_fix;

  assign accept    = start_i & ~annul_i;
  assign abort     = annul_i | ~start_i;
  assign last_iter = (cnt_reg == CW'(WIDTH - 1));

  // Negating the most negative value wraps to itself, which is exactly its
  // unsigned magnitude, so no special case is needed.
  assign abs1 = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
  assign abs2 = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

  // quo_reg doubles as the dividend shift register: dividend bits leave at the
  // top while quotient bits enter at the bottom.
  assign shifted  = {rem_reg, quo_reg[WIDTH-1]};
  assign fits     = (shifted >= {1'b0, divisor_reg});
  assign sub      = shifted[WIDTH-1:0] - divisor_reg;
  assign rem_step = fits ? sub : shifted[WIDTH-1:0];
  assign quo_step = {quo_reg[WIDTH-2:0], fits};
  assign quo_fix  = (neg1_reg ^ neg2_reg) ? -quo_step : quo_step;
  assign rem_fix  = neg1_reg ? -rem_step : rem_step;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      rem_reg     <= '0;
      quo_reg     <= '0;
      divisor_reg <= '0;
      neg1_reg    <= 1'b0;
      neg2_reg    <= 1'b0;
      result_reg  <= '0;
      ready_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      rem_reg     <= rem_next;
      quo_reg     <= quo_next;
      divisor_reg <= divisor_next;
      neg1_reg    <= neg1_next;
      neg2_reg    <= neg2_next;
      result_reg  <= result_next;
      ready_reg   <= ready_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (accept) state_next = (opdata2_i == '0) ? ST_BYZERO : ST_ON;
      ST_BYZERO: state_next = abort ? ST_IDLE : ST_END;
      ST_ON: begin
        if (abort)          state_next = ST_IDLE;
        else if (last_iter) state_next = ST_END;
      end
      ST_END:    if (!start_i) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_next     = cnt_reg;
    rem_next     = rem_reg;
    quo_next     = quo_reg;
    divisor_next = divisor_reg;
    neg1_next    = neg1_reg;
    neg2_next    = neg2_reg;
    result_next  = result_reg;
    ready_next   = ready_reg;
    case (state_reg)
      ST_IDLE: begin
        result_next = '0;
        ready_next  = 1'b0;
        cnt_next    = '0;
        if (accept && opdata2_i != '0) begin
          rem_next     = '0;
          quo_next     = abs1;
          divisor_next = abs2;
          neg1_next    = signed_div_i & opdata1_i[WIDTH-1];
          neg2_next    = signed_div_i & opdata2_i[WIDTH-1];
        end
      end
      ST_BYZERO: begin
        result_next = '0;
        ready_next  = ~abort;
        cnt_next    = '0;
      end
      ST_ON: begin
        if (abort) begin
          result_next = '0;
          ready_next  = 1'b0;
          cnt_next    = '0;
        end else begin
          rem_next = rem_step;
          quo_next = quo_step;
          cnt_next = cnt_reg + 1'b1;
          if (last_iter) begin
            result_next = {rem_fix, quo_fix};
            ready_next  = 1'b1;
          end
        end
      end
      ST_END: begin
        if (!start_i) begin
          result_next = '0;
          ready_next  = 1'b0;
        end
      end
      default: begin
        result_next = '0;
        ready_next  = 1'b0;
      end
    endcase
  end

  assign result_o   = result_reg;
  assign ready_o    = ready_reg;
  assign stallreq_o = start_i & ~ready_reg & ~annul_i;

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed edge cases, random divides against
// a plain-arithmetic reference, annul, and asynchronous reset.
module tb_div_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        annul = 1'b0;
  logic        sdiv = 1'b0;
  logic [31:0] op1 = '0;
  logic [31:0] op2 = '0;
  logic [63:0] result;
  logic        ready;
  logic        stallreq;

  int errors = 0;
  int checks = 0;

  div_seq #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start),
    .annul_i      (annul),
    .signed_div_i (sdiv),
    .opdata1_i    (op1),
    .opdata2_i    (op2),
    .result_o     (result),
    .ready_o      (ready),
    .stallreq_o   (stallreq)
  );

  always #5 clk = ~clk;

  // Reference: {remainder, quotient} from ordinary integer division.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
    longint la, lb, q, r;
    if (b == 0) return 64'd0;
    if (sgn) begin
      la = longint'($signed(a));
      lb = longint'($signed(b));
      q  = la / lb;
      r  = la % lb;
      return {r[31:0], q[31:0]};
    end
    return {a % b, a / b};
  endfunction

  // Counts edges after the accept edge until ready_o; flags any stall gap.
  task automatic wait_ready(output int lat, output bit stall_bad);
    lat = -1;
    stall_bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      lat++;
      if (ready === 1'b1) break;
      if (stallreq !== 1'b1) stall_bad = 1'b1;
    end
  endtask

  task automatic finish_check(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                              input logic [63:0] exp, input int lat, input bit stall_bad);
    int exp_lat;
    exp_lat = (b == 0) ? 1 : 32;
    checks++;
    if (lat !== exp_lat) begin
      errors++;
      $display("FAIL latency %h/%h: got %0d want %0d", a, b, lat, exp_lat);
    end
    checks++;
    if (stall_bad) begin
      errors++;
      $display("FAIL stall_gap %h/%h: stallreq dropped before ready", a, b);
    end
    checks++;
    if (result !== exp) begin
      errors++;
      $display("FAIL result %h/%h s=%0d: got %h want %h", a, b, sgn, result, exp);
    end
    checks++;
    if (stallreq !== 1'b0) begin
      errors++;
      $display("FAIL stall_at_ready %h/%h: got %b want 0", a, b, stallreq);
    end
    start = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (ready !== 1'b0 || result !== 64'd0) begin
      errors++;
      $display("FAIL drop_start %h/%h: ready=%b result=%h want 0/0", a, b, ready, result);
    end
    $display("div s=%0d %h / %h -> %h (lat %0d)", sgn, a, b, result_last(exp), lat);
  endtask

  function automatic logic [63:0] result_last(input logic [63:0] v);
    return v;
  endfunction

  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                         input logic [63:0] exp);
    int lat;
    bit stall_bad;
    @(negedge clk);
    start = 1'b1; op1 = a; op2 = b; sdiv = sgn;
    #1;
    checks++;
    if (stallreq !== 1'b1) begin
      errors++;
      $display("FAIL issue_stall %h/%h: got %b want 1", a, b, stallreq);
    end
    wait_ready(lat, stall_bad);
    finish_check(a, b, sgn, exp, lat, stall_bad);
    @(negedge clk);
  endtask

  task automatic test_reset;
    #12;
    checks++;
    if (ready !== 1'b0 || result !== 64'd0 || stallreq !== 1'b0) begin
      errors++;
      $display("FAIL reset: ready=%b result=%h stall=%b want 0", ready, result, stallreq);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed;
    logic [31:0] ta [6] = '{32'd100, 32'hFFFFFFF9, 32'd7, 32'hFFFFFFFF, 32'h80000000, 32'd3};
    logic [31:0] tb [6] = '{32'd7, 32'd2, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFF, 32'd5};
    logic        ts [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [63:0] te [6] = '{64'h00000002_0000000E, 64'hFFFFFFFF_FFFFFFFD,
                            64'h00000001_FFFFFFFD, 64'h00000000_FFFFFFFF,
                            64'h00000000_80000000, 64'h00000003_00000000};
    for (int i = 0; i < 6; i++) run_div(ta[i], tb[i], ts[i], te[i]);
  endtask

  task automatic test_div_by_zero;
    run_div(32'd1234, 32'd0, 1'b0, 64'd0);
    run_div(32'hFFFF0000, 32'd0, 1'b1, 64'd0);
  endtask

  task automatic test_random;
    logic [31:0] a, b;
    logic        s;
    for (int i = 0; i < 16; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'($urandom_range(1, 15));
        1: b = $urandom;
        2: b = {$urandom_range(0, 1) == 1 ? 16'hFFFF : 16'h0000, 16'($urandom)};
        default: b = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 1000));
      endcase
      s = 1'($urandom_range(0, 1));
      run_div(a, b, s, ref_div(a, b, s));
    end
  endtask

  task automatic test_annul;
    int lat;
    bit stall_bad;
    @(negedge clk);
    start = 1'b1; op1 = 32'd50; op2 = 32'd3; sdiv = 1'b0;
    repeat (11) @(negedge clk);
    annul = 1'b1;
    #1;
    checks++;
    if (stallreq !== 1'b0) begin
      errors++;
      $display("FAIL annul_stall: got %b want 0", stallreq);
    end
    // Fresh request presented right after the annul cycle must restart from scratch.
    @(negedge clk);
    annul = 1'b0; op1 = 32'd13; op2 = 32'd4;
    #1;
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("FAIL annul_ready: got %b want 0", ready);
    end
    wait_ready(lat, stall_bad);
    finish_check(32'd13, 32'd4, 1'b0, 64'h00000001_00000003, lat, stall_bad);
    @(negedge clk);
  endtask

  task automatic test_async_reset;
    int lat;
    bit stall_bad;
    bit seen;
    @(negedge clk);
    start = 1'b1; op1 = 32'h00012345; op2 = 32'd7; sdiv = 1'b0;
    repeat (6) @(negedge clk);
    #2;
    rst = 1'b1; start = 1'b0;
    #1;
    checks++;
    if (ready !== 1'b0 || result !== 64'd0) begin
      errors++;
      $display("FAIL reset_mid_on: ready=%b result=%h want 0", ready, result);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (ready !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL reset_no_result: ready asserted after reset, want 0");
    end
    run_div(32'd9, 32'd3, 1'b0, 64'h00000000_00000003);

    // Reset while a result is being held must clear it without waiting for a clock.
    @(negedge clk);
    start = 1'b1; op1 = 32'd100; op2 = 32'd7; sdiv = 1'b0;
    wait_ready(lat, stall_bad);
    checks++;
    if (ready !== 1'b1 || result !== 64'h00000002_0000000E) begin
      errors++;
      $display("FAIL pre_reset_end: ready=%b result=%h want 1/00000002_0000000e", ready, result);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (ready !== 1'b0 || result !== 64'd0) begin
      errors++;
      $display("FAIL reset_in_end: ready=%b result=%h want 0", ready, result);
    end
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    $display("async reset in END: ready=%b result=%h", ready, result);
    @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_directed;
    test_div_by_zero;
    test_random;
    test_annul;
    test_async_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
